// File: rtl/xspi_arb_pkg.sv
// Shared types and defaults for the xSPI PHY arbiter: FSM encoding,
// requester indices and default gap/timeout settings.
package xspi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    localparam int REQ_CSR = 0;
    localparam int REQ_AHB = 1;

    localparam int DEFAULT_CS_GAP         = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/xspi_arb_rr_pick.sv
// Two-way round-robin winner select: on a tie the requester that was not
// granted last wins; a lone requester always wins.
module xspi_arb_rr_pick
    import xspi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_ptr,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req[REQ_CSR] && req[REQ_AHB]) begin
            winner = ~last_ptr;
        end else if (req[REQ_AHB]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/xspi_phy_arbiter.sv
// Grants the shared xSPI PHY to the CSR or AHB engine one transfer at a time,
// with a minimum CS# deselect gap. Optional grant hold timeout: XSPI_ARB_TIMEOUT_EN.
module xspi_phy_arbiter
    import xspi_arb_pkg::*;
#(
    parameter int CS_GAP         = DEFAULT_CS_GAP,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        mem_clk,
    input  logic        mem_rst,
    input  logic [1:0]  req,
    input  logic [1:0]  done,
    output logic [1:0]  gnt,
    input  logic [1:0]  cs_n_ip_r,
    input  logic [1:0]  sclk_en_r,
    input  logic [31:0] dq_out_r,
    input  logic [31:0] dq_oe_r,
    output logic        cs_n_ip,
    output logic        sclk_en,
    output logic [15:0] dq_out_16,
    output logic [15:0] dq_oe,
    output logic        busy,
    output logic        timeout_intr
);

    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       owner_q, owner_d;
    logic       ptr_q, ptr_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;

    logic pick_valid;
    logic pick_winner;
    logic owner_done;
    logic timeout_hit;
    logic release_now;

    xspi_arb_rr_pick u_pick (
        .req      (req),
        .last_ptr (ptr_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    assign owner_done  = done[owner_q];
    assign release_now = owner_done || timeout_hit;

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b1;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot2(pick_winner);
                    owner_d = pick_winner;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d   = ST_GAP;
                    gnt_d     = 2'b00;
                    ptr_d     = owner_q;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

`ifdef XSPI_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        timeout_intr_q, timeout_intr_d;

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            hold_cnt_q     <= 16'd0;
            timeout_intr_q <= 1'b0;
        end else begin
            hold_cnt_q     <= hold_cnt_d;
            timeout_intr_q <= timeout_intr_d;
        end
    end

    // A done arriving on the last allowed cycle wins over the timeout.
    always_comb begin
        hold_cnt_d     = hold_cnt_q;
        timeout_hit    = 1'b0;
        timeout_intr_d = 1'b0;
        if (state_q == ST_IDLE) begin
            hold_cnt_d = 16'd0;
        end else if (state_q == ST_GRANT) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
            if (!owner_done && (hold_cnt_q == HOLD_LAST)) begin
                timeout_hit    = 1'b1;
                timeout_intr_d = 1'b1;
            end
        end
    end

    assign timeout_intr = timeout_intr_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |16'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
    assign timeout_intr       = 1'b0;
`endif

    // With no owner the PHY sees an idle, deselected bus.
    always_comb begin
        gnt  = gnt_q;
        busy = (state_q != ST_IDLE);
        if (gnt_q == 2'b00) begin
            cs_n_ip   = 1'b1;
            sclk_en   = 1'b0;
            dq_out_16 = 16'h0000;
            dq_oe     = 16'h0000;
        end else begin
            cs_n_ip   = cs_n_ip_r[owner_q];
            sclk_en   = sclk_en_r[owner_q];
            dq_out_16 = owner_q ? dq_out_r[31:16] : dq_out_r[15:0];
            dq_oe     = owner_q ? dq_oe_r[31:16]  : dq_oe_r[15:0];
        end
    end

endmodule

// File: tb/tb_xspi_phy_arbiter.sv
// Randomized self-checking bench for xspi_phy_arbiter against a transfer-level
// reference model; also models the XSPI_ARB_TIMEOUT_EN build.
module tb_xspi_phy_arbiter;

    localparam int TB_CS_GAP  = 4;
    localparam int TB_TIMEOUT = 16;

    logic        mem_clk = 1'b0;
    logic        mem_rst;
    logic [1:0]  req;
    logic [1:0]  done;
    logic [1:0]  gnt;
    logic [1:0]  cs_n_ip_r;
    logic [1:0]  sclk_en_r;
    logic [31:0] dq_out_r;
    logic [31:0] dq_oe_r;
    logic        cs_n_ip;
    logic        sclk_en;
    logic [15:0] dq_out_16;
    logic [15:0] dq_oe;
    logic        busy;
    logic        timeout_intr;

    always #5 mem_clk = ~mem_clk;

    xspi_phy_arbiter #(
        .CS_GAP         (TB_CS_GAP),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .mem_clk      (mem_clk),
        .mem_rst      (mem_rst),
        .req          (req),
        .done         (done),
        .gnt          (gnt),
        .cs_n_ip_r    (cs_n_ip_r),
        .sclk_en_r    (sclk_en_r),
        .dq_out_r     (dq_out_r),
        .dq_oe_r      (dq_oe_r),
        .cs_n_ip      (cs_n_ip),
        .sclk_en      (sclk_en),
        .dq_out_16    (dq_out_16),
        .dq_oe        (dq_oe),
        .busy         (busy),
        .timeout_intr (timeout_intr)
    );

    int total_checks = 0;
    int bad_checks   = 0;

    // Reference model: who owns the bus, who was served last, how many
    // forced-idle cycles remain after a release, and how long the grant is held.
    int m_owner    = -1;
    int m_last     = 1;
    int m_gap_left = 0;
    int m_held     = 0;
    bit m_intr     = 1'b0;
    bit pin_r1     = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ownerMask();
        if (m_owner < 0) return 2'b00;
        return (m_owner == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic modelStep(input logic [1:0] r, input logic [1:0] d, input logic rst);
        bit rel;
        m_intr = 1'b0;
        rel    = 1'b0;
        if (rst) begin
            m_owner    = -1;
            m_last     = 1;
            m_gap_left = 0;
            m_held     = 0;
        end else if (m_owner >= 0) begin
            rel = d[m_owner];
            if (!rel) begin
                m_held++;
`ifdef XSPI_ARB_TIMEOUT_EN
                if (m_held == TB_TIMEOUT) begin
                    rel    = 1'b1;
                    m_intr = 1'b1;
                end
`endif
            end
            if (rel) begin
                m_last     = m_owner;
                m_owner    = -1;
                m_gap_left = TB_CS_GAP;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (r != 2'b00) begin
            if (r == 2'b11) m_owner = 1 - m_last;
            else            m_owner = r[1] ? 1 : 0;
            m_held = 0;
        end
    endtask

    task automatic checkAll();
        logic        e_cs, e_sclk;
        logic [15:0] e_dq, e_oe;
        if (m_owner < 0) begin
            e_cs = 1'b1; e_sclk = 1'b0; e_dq = 16'h0; e_oe = 16'h0;
        end else if (m_owner == 1) begin
            e_cs = cs_n_ip_r[1]; e_sclk = sclk_en_r[1];
            e_dq = dq_out_r[31:16]; e_oe = dq_oe_r[31:16];
        end else begin
            e_cs = cs_n_ip_r[0]; e_sclk = sclk_en_r[0];
            e_dq = dq_out_r[15:0]; e_oe = dq_oe_r[15:0];
        end
        checkOutput("gnt",          32'(gnt),          32'(ownerMask()));
        checkOutput("cs_n_ip",      32'(cs_n_ip),      32'(e_cs));
        checkOutput("sclk_en",      32'(sclk_en),      32'(e_sclk));
        checkOutput("dq_out_16",    32'(dq_out_16),    32'(e_dq));
        checkOutput("dq_oe",        32'(dq_oe),        32'(e_oe));
        checkOutput("busy",         32'(busy),         32'((m_owner >= 0) || (m_gap_left > 0)));
        checkOutput("timeout_intr", 32'(timeout_intr), 32'(m_intr));
    endtask

    // Drive one cycle of inputs at the falling edge, check, then advance.
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d, input logic rst);
        req       = r;
        done      = d;
        mem_rst   = rst;
        cs_n_ip_r = 2'($urandom);
        sclk_en_r = 2'($urandom);
        dq_out_r  = $urandom;
        dq_oe_r   = $urandom;
        if (pin_r1) begin
            cs_n_ip_r[1]     = 1'b0;
            sclk_en_r[1]     = 1'b1;
            dq_out_r[31:16]  = 16'hA55A;
            dq_oe_r[31:16]   = 16'hFFFF;
        end
        #1;
        checkAll();
        @(posedge mem_clk);
        modelStep(r, d, rst);
        @(negedge mem_clk);
    endtask

    initial begin
        mem_rst   = 1'b1;
        req       = 2'b00;
        done      = 2'b00;
        cs_n_ip_r = 2'b11;
        sclk_en_r = 2'b00;
        dq_out_r  = 32'h0;
        dq_oe_r   = 32'h0;
        @(posedge mem_clk);
        @(negedge mem_clk);

        $display("[TB] reset and single CSR transfer");
        repeat (3) applyStimulus(2'b00, 2'b00, 1'b1);
        repeat (2) applyStimulus(2'b00, 2'b00, 1'b0);
        repeat (6) applyStimulus(2'b01, 2'b00, 1'b0);
        applyStimulus(2'b01, 2'b10, 1'b0);
        repeat (6) applyStimulus(2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b01, 1'b0);
        repeat (8) applyStimulus(2'b00, 2'b00, 1'b0);

        $display("[TB] back-to-back alternation");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(2'b11, (m_owner >= 0 && m_held == 5) ? ownerMask() : 2'b00, 1'b0);
        end
        repeat (8) applyStimulus(2'b00, 2'b00, 1'b0);

        $display("[TB] AHB owner with CSR noise");
        pin_r1 = 1'b1;
        for (int i = 0; i < 12 && m_owner != 1; i++) applyStimulus(2'b10, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(2'b00, (i % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b10, 1'b0);
        pin_r1 = 1'b0;
        repeat (8) applyStimulus(2'b00, 2'b00, 1'b0);

        $display("[TB] reset mid-transfer");
        for (int i = 0; i < 12 && m_owner < 0; i++) applyStimulus(2'b11, 2'b00, 1'b0);
        repeat (3) applyStimulus(2'b11, 2'b00, 1'b0);
        applyStimulus(2'b11, 2'b00, 1'b1);
        repeat (4) applyStimulus(2'b11, 2'b00, 1'b0);

        $display("[TB] request pulse during gap");
        applyStimulus(2'b00, ownerMask(), 1'b0);
        applyStimulus(2'b10, 2'b00, 1'b0);
        repeat (8) applyStimulus(2'b00, 2'b00, 1'b0);

        $display("[TB] long hold without done");
        repeat (45) applyStimulus(2'b11, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b11, 1'b0);
        repeat (8) applyStimulus(2'b00, 2'b00, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] r, d;
            r = 2'($urandom);
            d[0] = ($urandom_range(7) == 0);
            d[1] = ($urandom_range(7) == 0);
            applyStimulus(r, d, ($urandom_range(399) == 0));
        end

        req  = 2'b00;
        done = 2'b00;
        #1;
        checkAll();

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
